// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: request/grant/read-data bus for three pixel clients; master = clients, slave = arbiter
interface sram_port_arbiter_if #(
  parameter int X_MAX = 5,
  parameter int Y_MAX = 5,
  parameter int DATA_W = 8
);
  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;
  logic [2:0] req_valid;
  logic [2:0] req_we;
  logic [2:0] req_lock;
  logic [3*XW-1:0] req_x;
  logic [3*YW-1:0] req_y;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0] req_grant;
  logic [2:0] rvalid;
  logic [DATA_W-1:0] rdata;
  modport master (
    output req_valid, req_we, req_lock, req_x, req_y, req_wdata,
    input req_grant, rvalid, rdata
  );
  modport slave (
    input req_valid, req_we, req_lock, req_x, req_y, req_wdata,
    output req_grant, rvalid, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin single-port SRAM arbiter with locked bursts and (x,y)->linear addressing; ports clk/rst, bus (client requests, grants, tagged read data), sram_* (SRAM command and read data), clr_err/oob_err (sticky out-of-range flag)
module sram_port_arbiter #(
  parameter int X_MAX = 5,
  parameter int Y_MAX = 5,
  parameter int DATA_W = 8,
  parameter int BURST_MAX = 16,
  localparam int XW = $clog2(X_MAX) + 1,
  localparam int YW = $clog2(Y_MAX) + 1,
  localparam int AW = $clog2(X_MAX * Y_MAX)
) (
  input  logic clk,
  input  logic rst,
  sram_port_arbiter_if.slave bus,
  output logic sram_en,
  output logic sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic clr_err,
  output logic oob_err
);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BM1 = CW'(BURST_MAX - 1);
  localparam logic [XW-1:0] XM = XW'(X_MAX);
  localparam logic [YW-1:0] YM = YW'(Y_MAX);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state;
  logic [1:0] last, win, p0, p1;
  logic [CW-1:0] burst_cnt;
  logic [2:0] grant, rvalid, others;
  logic lock_q, cmd_we, cmd_oob, rd_zero, keep, oob, we, lock;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    p0 = last == 2'd2 ? 2'd0 : last + 2'd1;
    p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    others = bus.req_valid & ~(3'b001 << last);
    // the locked owner keeps the port unless its burst is spent and someone else is waiting
    keep = state == OWNED && lock_q && bus.req_valid[last] && (burst_cnt != BM1 || others == 3'b000);
    win = keep ? last : bus.req_valid[p0] ? p0 : bus.req_valid[p1] ? p1 : last;
    x = '0;
    y = '0;
    wdata = '0;
    we = 1'b0;
    lock = 1'b0;
    for (int i = 0; i < 3; i++)
      if (win == 2'(i)) begin
        x = bus.req_x[i*XW +: XW];
        y = bus.req_y[i*YW +: YW];
        wdata = bus.req_wdata[i*DATA_W +: DATA_W];
        we = bus.req_we[i];
        lock = bus.req_lock[i];
      end
    oob = x >= XM || y >= YM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 2'd2;
      burst_cnt <= '0;
      lock_q <= 1'b0;
      cmd_we <= 1'b0;
      cmd_oob <= 1'b0;
      rd_zero <= 1'b0;
      grant <= '0;
      rvalid <= '0;
      sram_en <= 1'b0;
      sram_we <= 1'b0;
      sram_addr <= '0;
      sram_wdata <= '0;
      oob_err <= 1'b0;
    end else begin
      rvalid <= cmd_we ? 3'b000 : grant;
      rd_zero <= cmd_oob;
      oob_err <= (|bus.req_valid && oob) || (oob_err && !clr_err);
      if (|bus.req_valid) begin
        state <= OWNED;
        last <= win;
        burst_cnt <= keep && burst_cnt != BM1 ? burst_cnt + 1'b1 : '0;
        grant <= 3'b001 << win;
        lock_q <= lock;
        cmd_we <= we;
        cmd_oob <= oob;
        sram_en <= !oob;
        sram_we <= we && !oob;
        sram_addr <= AW'(y) * AW'(X_MAX) + AW'(x);
        sram_wdata <= wdata;
      end else begin
        state <= IDLE;
        burst_cnt <= '0;
        grant <= '0;
        lock_q <= 1'b0;
        cmd_we <= 1'b0;
        cmd_oob <= 1'b0;
        sram_en <= 1'b0;
        sram_we <= 1'b0;
      end
    end
  end
  assign bus.req_grant = grant;
  assign bus.rvalid = rvalid;
  // out-of-range reads answer with zero instead of whatever the idle SRAM drives
  assign bus.rdata = |rvalid && !rd_zero ? sram_rdata : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and randomized checks of sram_port_arbiter against a transaction-level model
module tb_sram_port_arbiter;
  localparam int BM = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_err = 1'b0;
  logic sram_en, sram_we, oob_err;
  logic [4:0] sram_addr;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata = 8'h00;
  logic [7:0] mem [0:31];
  sram_port_arbiter_if #(.X_MAX(5), .Y_MAX(5), .DATA_W(8)) bus ();
  sram_port_arbiter #(.X_MAX(5), .Y_MAX(5), .DATA_W(8), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .clr_err(clr_err), .oob_err(oob_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
  end
  int n_cmp = 0;
  int n_err = 0;
  logic r_v [3];
  logic r_we [3];
  logic r_lock [3];
  logic [3:0] r_x [3];
  logic [3:0] r_y [3];
  logic [7:0] r_wd [3];
  bit keep_req [3];
  bit rnd = 0;
  logic [7:0] sm [0:31];
  int last_m = 2;
  int own = -1;
  int run = 0;
  logic own_lock = 1'b0;
  logic [2:0] pend_rv = '0;
  logic [7:0] pend_rd = '0;
  logic eoob = 1'b0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      bus.req_valid[i] = r_v[i];
      bus.req_we[i] = r_we[i];
      bus.req_lock[i] = r_lock[i];
      bus.req_x[i*4 +: 4] = r_x[i];
      bus.req_y[i*4 +: 4] = r_y[i];
      bus.req_wdata[i*8 +: 8] = r_wd[i];
    end
  endtask
  task automatic set_req(int i, logic v, logic we, logic lk, int x, int y, logic [7:0] wd);
    r_v[i] = v;
    r_we[i] = we;
    r_lock[i] = lk;
    r_x[i] = 4'(x);
    r_y[i] = 4'(y);
    r_wd[i] = wd;
  endtask
  task automatic new_req(int i);
    set_req(i, 1'b1, $urandom % 3 == 0, $urandom % 2 == 1,
            $urandom % 12 == 0 ? 5 + $urandom % 3 : $urandom % 5,
            $urandom % 12 == 0 ? 5 + $urandom % 3 : $urandom % 5, 8'($urandom));
  endtask
  // one clock: predict from the rules, step the clock, compare, then let clients react to grants
  task automatic cycle();
    int w, addr;
    logic [2:0] eg, erv;
    logic [7:0] erd, ewd;
    logic [4:0] eaddr;
    logic een, ewe, oob, others;
    drive();
    w = -1;
    een = 1'b0;
    ewe = 1'b0;
    eaddr = '0;
    ewd = '0;
    oob = 1'b0;
    erv = pend_rv;
    erd = pend_rd;
    if (rst) begin
      last_m = 2;
      own = -1;
      run = 0;
      own_lock = 1'b0;
      pend_rv = '0;
      pend_rd = '0;
      eoob = 1'b0;
      erv = '0;
    end else begin
      others = 1'b0;
      for (int k = 0; k < 3; k++) if (k != own && r_v[k]) others = 1'b1;
      if (own >= 0 && own_lock && r_v[own] && (run < BM || !others)) w = own;
      else for (int k = 1; k <= 3; k++) if (w < 0 && r_v[(last_m + k) % 3]) w = (last_m + k) % 3;
      if (w >= 0) begin
        run = (w == own && own_lock && run < BM) ? run + 1 : 1;
        oob = r_x[w] >= 5 || r_y[w] >= 5;
        addr = r_y[w] * 5 + r_x[w];
        eaddr = 5'(addr);
        een = !oob;
        ewe = een && r_we[w];
        ewd = r_wd[w];
        if (ewe) sm[eaddr] = r_wd[w];
        pend_rv = r_we[w] ? 3'b000 : 3'b001 << w;
        pend_rd = (r_we[w] || oob) ? 8'h00 : sm[eaddr];
        own = w;
        own_lock = r_lock[w];
        last_m = w;
      end else begin
        own = -1;
        run = 0;
        pend_rv = '0;
        pend_rd = '0;
      end
      eoob = oob || (eoob && !clr_err);
    end
    eg = w >= 0 ? 3'b001 << w : 3'b000;
    @(posedge clk);
    #1;
    chk("grant", bus.req_grant, eg);
    chk("sram_en", sram_en, een);
    chk("sram_we", sram_we, ewe);
    if (een) chk("sram_addr", sram_addr, eaddr);
    if (ewe) chk("sram_wdata", sram_wdata, ewd);
    chk("rvalid", bus.rvalid, erv);
    if (erv != 0) chk("rdata", bus.rdata, erd);
    chk("oob_err", oob_err, eoob);
    if (w >= 0 && !keep_req[w]) r_v[w] = 1'b0;
    if (rnd) for (int i = 0; i < 3; i++) if (!r_v[i] && $urandom % 2 == 0) new_req(i);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] <= i == 17 ? 8'hA5 : 8'(i * 37 + 11);
      sm[i] = i == 17 ? 8'hA5 : 8'(i * 37 + 11);
    end
    for (int i = 0; i < 3; i++) begin
      set_req(i, 1'b1, 1'b0, 1'b0, i, i, 8'h00);
      keep_req[i] = 1;
    end
    for (int n = 0; n < 2; n++) begin
      cycle();
      chk("rst_grant", bus.req_grant, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_en", sram_en, 0);
      chk("rst_we", sram_we, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_wdata", sram_wdata, 0);
      chk("rst_oob", oob_err, 0);
    end
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      cycle();
      chk("contention_grant", bus.req_grant, 3'b001 << (n % 3));
      chk("contention_en", sram_en, 1);
    end
    for (int i = 0; i < 3; i++) keep_req[i] = 0;
    for (int n = 0; n < 3; n++) cycle();
    set_req(2, 1'b1, 1'b0, 1'b0, 2, 3, 8'h00);
    cycle();
    chk("single_grant", bus.req_grant, 3'b100);
    chk("single_addr", sram_addr, 17);
    cycle();
    chk("single_rvalid", bus.rvalid, 3'b100);
    chk("single_rdata", bus.rdata, 8'hA5);
    cycle();
    set_req(1, 1'b1, 1'b0, 1'b1, 1, 1, 8'h00);
    keep_req[1] = 1;
    cycle();
    chk("burst_first", bus.req_grant, 3'b010);
    set_req(0, 1'b1, 1'b0, 1'b0, 4, 0, 8'h00);
    set_req(2, 1'b1, 1'b1, 1'b0, 0, 4, 8'h5A);
    keep_req[0] = 1;
    keep_req[2] = 1;
    for (int n = 0; n < 6; n++) begin
      logic [2:0] seq [6] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};
      cycle();
      chk("burst_seq", bus.req_grant, seq[n]);
    end
    keep_req[0] = 0;
    keep_req[2] = 0;
    for (int n = 0; n < 12; n++) begin
      cycle();
      if (n >= 7) chk("burst_alone", bus.req_grant, 3'b010);
    end
    keep_req[1] = 0;
    for (int n = 0; n < 3; n++) cycle();
    set_req(0, 1'b1, 1'b1, 1'b0, 5, 0, 8'h3C);
    cycle();
    chk("oob_grant", bus.req_grant, 3'b001);
    chk("oob_en", sram_en, 0);
    chk("oob_flag", oob_err, 1);
    set_req(0, 1'b1, 1'b0, 1'b0, 6, 0, 8'h00);
    cycle();
    chk("oob_rd_grant", bus.req_grant, 3'b001);
    cycle();
    chk("oob_rvalid", bus.rvalid, 3'b001);
    chk("oob_rdata", bus.rdata, 0);
    clr_err = 1'b1;
    cycle();
    chk("oob_clear", oob_err, 0);
    set_req(0, 1'b1, 1'b0, 1'b0, 0, 9, 8'h00);
    cycle();
    chk("oob_set_wins", oob_err, 1);
    cycle();
    chk("oob_clear2", oob_err, 0);
    clr_err = 1'b0;
    cycle();
    set_req(1, 1'b1, 1'b0, 1'b0, 3, 2, 8'h00);
    cycle();
    chk("mid_grant", bus.req_grant, 3'b010);
    rst = 1'b1;
    cycle();
    chk("mid_rvalid", bus.rvalid, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, 1, 2, 8'h00);
    cycle();
    chk("mid_restart", bus.req_grant, 3'b001);
    for (int n = 0; n < 4; n++) cycle();
    rnd = 1;
    for (int n = 0; n < 4000; n++) begin
      rst = $urandom % 400 == 0;
      clr_err = $urandom % 16 == 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port pixel SRAM between three requesters: host loader (req 0), Gaussian stage (req 1) and FAST stage (req 2). The FAST stage uses its port for `read_SRAM2` pixel fetches and `write_SRAM4` corner writes.
- Arbitration is round-robin, with optional locked bursts for row-streaming clients.
- The block converts (x, y) pixel coordinates into linear SRAM addresses and returns tagged read data with fixed latency.

## Interface
Parameters:
- `X_MAX`, default 5: image width in pixels; linear address = y*X_MAX + x.
- `Y_MAX`, default 5: image height in pixels.
- `DATA_W`, default 8: pixel width.
- `BURST_MAX`, default 16: maximum consecutive locked grants before forced rotation.
- Derived `XW` = $clog2(X_MAX)+1 and `YW` = $clog2(Y_MAX)+1: coordinate widths.
- Derived `AW` = $clog2(X_MAX*Y_MAX): SRAM address width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  3  per-requester request valid.
- `req_we`  in  3  per-requester write enable; 1 = write, 0 = read.
- `req_lock`  in  3  per-requester burst lock request.
- `req_x`  in  3*XW  packed x coordinates; requester i at bits [i*XW +: XW].
- `req_y`  in  3*YW  packed y coordinates.
- `req_wdata`  in  3*DATA_W  packed write data.
- `req_grant`  out  3  one-hot; pulses for one cycle when the request is accepted.
- `rvalid`  out  3  one-hot read-data valid.
- `rdata`  out  DATA_W  read data, shared by all requesters.
- `sram_en`  out  1  SRAM access enable.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  AW  SRAM linear address.
- `sram_wdata`  out  DATA_W  SRAM write data.
- `sram_rdata`  in  DATA_W  SRAM read data; valid the cycle after `sram_en`/!`sram_we`.
- `clr_err`  in  1  clears `oob_err`.
- `oob_err`  out  1  sticky out-of-range coordinate flag.

## Operation
State machine:
- IDLE: no owner.
  - At a rising edge with any `req_valid`, pick the winner by round-robin starting at `last+1` (mod 3).
  - Register the winner's command and go to OWNED(i).
- OWNED(i): owner i was granted in the current cycle.
  - At the next edge, if `req_valid[i]` and `req_lock[i]` were high at i's previous grant, and `burst_cnt` < BURST_MAX-1, i wins again and `burst_cnt` increments.
  - Otherwise round-robin from i+1. Go to IDLE if nothing is valid.
  - `burst_cnt` clears on any owner change or on IDLE.
- Forced rotation: when `burst_cnt` = BURST_MAX-1, the next edge skips i if any other requester is valid.
  - If no other requester is valid, i wins and `burst_cnt` restarts at 0.
- Pointer: `last` is updated to each winner.

Address and range rules:
- Address arithmetic: `sram_addr` = y*X_MAX + x, computed at full width and truncated to AW.
- Out of range (x ≥ X_MAX or y ≥ Y_MAX):
  - The grant is still issued and `sram_en` stays 0.
  - A read returns `rdata` = 0 with the normal `rvalid`.
  - A write is dropped.
  - `oob_err` sets.

`oob_err` behaviour:
- It clears on `rst` or `clr_err`.
- If set and clear occur in the same cycle, set wins.

## Timing
- Requests are sampled at rising edges. The winner's fields are captured at edge k.
- During cycle k+1:
  - `req_grant[i]` = 1.
  - `sram_en`/`sram_we`/`sram_addr`/`sram_wdata` carry the command.
- The requester may change fields or deassert valid during its grant cycle. Its next request is sampled at edge k+1.
- Read latency: `rvalid[i]` and `rdata` appear in cycle k+2, one cycle after the grant.
- Throughput: one access per cycle, with back-to-back grants to the same or different requesters.
- Requests that are not granted must hold their fields stable until granted. The arbiter never drops a valid request.
- Outputs are 0 after reset: all `req_grant`, `rvalid`, `rdata`, `sram_en`, `sram_we`, `sram_addr`, `sram_wdata`, and `oob_err`.
- Internal state after reset: `last` = 2, so req 0 is first priority; FSM = IDLE; `burst_cnt` = 0.
- Reset mid-operation: a pending `rvalid` is suppressed. A command issued in the same cycle as `rst` still reaches the SRAM, but no response is returned.

## Test plan
- Reset: assert `rst` 2 cycles with all requests valid -> all outputs 0 throughout. The first grant after release goes to req 0.
- Single read, req 2, x=2, y=3, X_MAX=5, SRAM[17]=0xA5:
  - `req_grant`=3'b100 and `sram_addr`=17 at k+1.
  - `rvalid`=3'b100 and `rdata`=0xA5 at k+2.
- Contention, all three valid continuously with no lock -> grants 0,1,2,0,1,2 on consecutive cycles, with `sram_en` high every cycle.
- Locked burst, BURST_MAX=4, req 1 locked, reqs 0 and 2 valid -> grants 1,1,1,1,2,0,1…. With only req 1 valid, req 1 is granted every cycle.
- Out of range: req 0 write at x=5, y=0 -> grant issued, `sram_en`=0, `oob_err`=1. A following read of x=6 returns `rdata`=0. `clr_err` clears the flag.
- Reset mid-burst: `rst` the cycle after a read grant -> no `rvalid` the next cycle. Arbitration restarts at req 0.
